// File: rtl/multibit_fifo_deep.sv
// multibit_fifo_deep: single-clock show-ahead FIFO, DEPTH x DATA_WIDTH.
// Valid/ready push port (a*) and pop port (b*). Also provides a registered
// occupancy count, almost-full/almost-empty flags and a synchronous flush.
// Optional feature: define MULTIBIT_FIFO_BYPASS_EN to let a word pushed into
// an empty FIFO appear on the b-side in the same cycle.
module multibit_fifo_deep #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 8,
  parameter int AFULL_LEVEL  = 6,
  parameter int AEMPTY_LEVEL = 1,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  avalid,
  input  logic [DATA_WIDTH-1:0] adata,
  output logic                  aready,
  output logic                  bvalid,
  output logic [DATA_WIDTH-1:0] bdata,
  input  logic                  bready,
  output logic [AW:0]           count,
  output logic                  afull,
  output logic                  aempty
);

  localparam logic [AW:0] AFULL_LVL  = (AW+1)'(AFULL_LEVEL);
  localparam logic [AW:0] AEMPTY_LVL = (AW+1)'(AEMPTY_LEVEL);
  localparam logic [AW:0] ONE        = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;

  // Storage is deliberately not reset; bdata is only meaningful with bvalid.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic empty, full;
  logic push, pop;

  // Pointer-derived status.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  end

`ifdef MULTIBIT_FIFO_BYPASS_EN
  logic byp;

  // Handshakes with same-cycle pass-through when empty.
  always_comb begin
    aready = ~reset & ~full & ~flush;
    byp    = empty & avalid & ~flush & ~reset;
    bvalid = (~empty & ~flush) | byp;
    bdata  = byp ? adata : mem[rptr_q[AW-1:0]];
    // A bypassed word that is consumed immediately never touches storage;
    // if it is not consumed it is written like any other push.
    push   = avalid & aready & ~(byp & bready);
    pop    = bvalid & bready & ~byp;
  end
`else
  // Handshakes; b-side depends only on registered state and flush.
  always_comb begin
    aready = ~reset & ~full & ~flush;
    bvalid = ~empty & ~flush;
    bdata  = mem[rptr_q[AW-1:0]];
    push   = avalid & aready;
    pop    = bvalid & bready;
  end
`endif

  // Next-state for pointers and occupancy; flush overrides any transfer.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + ONE;
      if (pop)  rptr_d = rptr_q + ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write; push is already gated by reset, flush and full.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= adata;
  end

  // Threshold flags from the registered count only.
  always_comb begin
    count  = count_q;
    afull  = (count_q >= AFULL_LVL);
    aempty = (count_q <= AEMPTY_LVL);
  end

endmodule
